// File: rtl/hpu_qpipe_sink_pkg.sv
// Shared types and helpers for the qualified-pipe credit sink.
package hpu_qpipe_sink_pkg;

  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic ovf;
    logic cred;
  } sink_err_t;

endpackage

// File: rtl/hpu_qpipe_sink_chk.sv
// Structural invariants of the credit sink, bound alongside the top level.
module hpu_qpipe_sink_chk
  import hpu_qpipe_sink_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic                     clk,
  input logic                     a_rst_n,
  input logic [cred_w(DEPTH)-1:0] credit_cnt,
  input logic                     credit_avail,
  input logic [cred_w(DEPTH)-1:0] occupancy,
  input logic                     out_vld,
  input logic                     empty,
  input logic                     full,
  input logic                     push_ok,
  input logic                     pop
);

  localparam int CW = cred_w(DEPTH);

  a_cred_max: assert property (@(posedge clk) disable iff (!a_rst_n)
    credit_cnt <= CW'(DEPTH));

  a_occ_max: assert property (@(posedge clk) disable iff (!a_rst_n)
    occupancy <= CW'(DEPTH));

  a_avail: assert property (@(posedge clk) disable iff (!a_rst_n)
    credit_avail == (credit_cnt != CW'(0)));

  a_vld: assert property (@(posedge clk) disable iff (!a_rst_n)
    (out_vld == !empty) && (empty == (occupancy == CW'(0))));

  a_push_room: assert property (@(posedge clk) disable iff (!a_rst_n)
    push_ok |-> (!full || pop));

endmodule

// File: rtl/hpu_qpipe_sink_fifo.sv
// DEPTH-entry FIFO with registered storage, combinational head read and an explicit occupancy counter.
module hpu_qpipe_sink_fifo
  import hpu_qpipe_sink_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      a_rst_n,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      out_rdy,
  output logic                      out_vld,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      full,
  output logic                      empty,
  output logic                      push_ok,
  output logic                      pop,
  output logic [cred_w(DEPTH)-1:0]  occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = cred_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [OW-1:0]         occ_r;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) begin
      return PW'(0);
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  assign empty     = (occ_r == OW'(0));
  assign full      = (occ_r == OW'(DEPTH));
  assign pop       = !empty && out_rdy;
  assign push_ok   = push && (!full || pop);
  assign out_vld   = !empty;
  assign out_data  = mem_r[rd_ptr_r];
  assign occupancy = occ_r;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      occ_r    <= OW'(0);
    end else begin
      if (push_ok) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_ok, pop})
        2'b10:   occ_r <= occ_r + OW'(1);
        2'b01:   occ_r <= occ_r - OW'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Payload storage; contents are meaningless until written so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

endmodule

// File: rtl/hpu_qpipe_credit_sink.sv
// Credit-returning consumer for a fixed-latency qualified pipe: FIFO, credit counter and sticky errors.
module hpu_qpipe_credit_sink
  import hpu_qpipe_sink_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int PIPE_LAT   = 1
) (
  input  logic                      clk,
  input  logic                      a_rst_n,
  output logic                      credit_avail,
  input  logic                      issue,
  input  logic                      in_vld,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [cred_w(DEPTH)-1:0]  credit_cnt,
  output logic                      err_ovf,
  output logic                      err_cred
);

  localparam int CW = cred_w(DEPTH);

  if (DEPTH < 2 || PIPE_LAT < 0) begin : g_bad_param
    $error("hpu_qpipe_credit_sink: DEPTH must be >= 2 and PIPE_LAT >= 0");
  end

  logic          full_s;
  logic          empty_s;
  logic          push_ok_s;
  logic          pop_s;
  logic [CW-1:0] occ_s;
  logic [CW-1:0] cred_nxt_s;
  logic [CW-1:0] credit_cnt_r;
  logic          credit_avail_r;
  sink_err_t     err_r;

  hpu_qpipe_sink_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .a_rst_n   (a_rst_n),
    .push      (in_vld),
    .in_data   (in_data),
    .out_rdy   (out_rdy),
    .out_vld   (out_vld),
    .out_data  (out_data),
    .full      (full_s),
    .empty     (empty_s),
    .push_ok   (push_ok_s),
    .pop       (pop_s),
    .occupancy (occ_s)
  );

  // Next credit value: saturate at both ends, a simultaneous issue and pop cancel.
  always_comb begin
    cred_nxt_s = credit_cnt_r;
    case ({issue, pop_s})
      2'b10: begin
        if (credit_cnt_r != CW'(0)) begin
          cred_nxt_s = credit_cnt_r - CW'(1);
        end else begin
          cred_nxt_s = credit_cnt_r;
        end
      end
      2'b01: begin
        if (credit_cnt_r != CW'(DEPTH)) begin
          cred_nxt_s = credit_cnt_r + CW'(1);
        end else begin
          cred_nxt_s = credit_cnt_r;
        end
      end
      default: cred_nxt_s = credit_cnt_r;
    endcase
  end

  // Credit counter, registered availability flag and sticky error flags.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      credit_cnt_r   <= CW'(DEPTH);
      credit_avail_r <= 1'b1;
      err_r          <= '0;
    end else begin
      credit_cnt_r   <= cred_nxt_s;
      credit_avail_r <= (cred_nxt_s != CW'(0));
      err_r.ovf      <= err_r.ovf  | (in_vld & full_s & ~pop_s);
      err_r.cred     <= err_r.cred | (issue & (credit_cnt_r == CW'(0)));
    end
  end

  assign credit_cnt   = credit_cnt_r;
  assign credit_avail = credit_avail_r;
  assign err_ovf      = err_r.ovf;
  assign err_cred     = err_r.cred;

  hpu_qpipe_sink_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk          (clk),
    .a_rst_n      (a_rst_n),
    .credit_cnt   (credit_cnt_r),
    .credit_avail (credit_avail_r),
    .occupancy    (occ_s),
    .out_vld      (out_vld),
    .empty        (empty_s),
    .full         (full_s),
    .push_ok      (push_ok_s),
    .pop          (pop_s)
  );

endmodule

// File: tb/tb_hpu_qpipe_credit_sink.sv
// Self-checking bench: emulated 3-stage pipe feeding the sink, queue/integer reference model.
module tb_hpu_qpipe_credit_sink;

  localparam int DW = 32;
  localparam int DP = 8;
  localparam int PL = 3;

  logic          clk = 1'b0;
  logic          a_rst_n;
  logic          credit_avail;
  logic          issue;
  logic          in_vld;
  logic [DW-1:0] in_data;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic [3:0]    credit_cnt;
  logic          err_ovf;
  logic          err_cred;

  int            errors = 0;
  int            checks = 0;

  logic [DW-1:0] mq[$];
  int            mcred;
  bit            m_ovf;
  bit            m_cred;
  bit            pv [PL];
  logic [DW-1:0] pd [PL];

  hpu_qpipe_credit_sink #(
    .DATA_WIDTH (DW),
    .DEPTH      (DP),
    .PIPE_LAT   (PL)
  ) dut (
    .clk          (clk),
    .a_rst_n      (a_rst_n),
    .credit_avail (credit_avail),
    .issue        (issue),
    .in_vld       (in_vld),
    .in_data      (in_data),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_data     (out_data),
    .credit_cnt   (credit_cnt),
    .err_ovf      (err_ovf),
    .err_cred     (err_cred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mcred  = DP;
    m_ovf  = 1'b0;
    m_cred = 1'b0;
    for (int i = 0; i < PL; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
  endtask

  task automatic check_all();
    chk("credit_cnt", 32'(credit_cnt), 32'(mcred));
    chk("credit_avail", 32'(credit_avail), 32'(mcred != 0));
    chk("out_vld", 32'(out_vld), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("out_data", out_data, mq[0]);
    chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
    chk("err_cred", 32'(err_cred), 32'(m_cred));
  endtask

  // One clock: drive at negedge, update model at posedge, compare at the following negedge.
  task automatic cycle(input bit iss, input logic [DW-1:0] d, input bit rdy,
                       input bit fv = 1'b0, input logic [DW-1:0] fd = '0);
    bit            pop;
    bit            ivld;
    logic [DW-1:0] idat;
    int            sz0;
    ivld    = pv[PL-1] | fv;
    idat    = pv[PL-1] ? pd[PL-1] : fd;
    issue   = iss;
    in_vld  = ivld;
    in_data = idat;
    out_rdy = rdy;
    sz0     = mq.size();
    pop     = (sz0 > 0) && rdy;
    @(posedge clk);
    if (iss && mcred == 0) m_cred = 1'b1;
    if (iss && !pop) begin
      if (mcred > 0) mcred--;
    end else if (pop && !iss) begin
      if (mcred < DP) mcred++;
    end
    if (pop) void'(mq.pop_front());
    if (ivld) begin
      if (sz0 < DP || pop) mq.push_back(idat);
      else m_ovf = 1'b1;
    end
    for (int i = PL - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = iss;
    pd[0] = d;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    issue   = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
    out_rdy = 1'b0;
    a_rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    a_rst_n = 1'b1;

    // Reset state
    chk("rst_credit", 32'(credit_cnt), 32'd8);
    chk("rst_avail", 32'(credit_avail), 32'd1);
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_errs", 32'({err_ovf, err_cred}), 32'd0);

    // Latency through a 3-deep pipe
    cycle(1'b1, 32'hA5, 1'b0);
    chk("lat_credit7", 32'(credit_cnt), 32'd7);
    repeat (3) cycle(1'b0, '0, 1'b0);
    chk("lat_vld", 32'(out_vld), 32'd1);
    chk("lat_data", out_data, 32'hA5);
    cycle(1'b0, '0, 1'b1);
    chk("lat_credit8", 32'(credit_cnt), 32'd8);

    // Fill then drain in order
    for (int i = 0; i < DP; i++) cycle(1'b1, 32'(i), 1'b0);
    chk("fill_avail0", 32'(credit_avail), 32'd0);
    repeat (PL) cycle(1'b0, '0, 1'b0);
    chk("fill_head", out_data, 32'd0);
    for (int i = 0; i < DP; i++) begin
      chk("drain_order", out_data, 32'(i));
      cycle(1'b0, '0, 1'b1);
    end
    chk("drain_credit", 32'(credit_cnt), 32'd8);
    chk("drain_empty", 32'(out_vld), 32'd0);

    // Full FIFO with simultaneous push and pop, across the pointer wrap
    for (int i = 0; i < DP; i++) cycle(1'b1, 32'h10 + 32'(i), 1'b0);
    repeat (PL) cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1, 32'h99);
    chk("simul_vld", 32'(out_vld), 32'd1);
    chk("simul_no_ovf", 32'(err_ovf), 32'd0);
    for (int i = 1; i < DP; i++) begin
      chk("simul_order", out_data, 32'h10 + 32'(i));
      cycle(1'b0, '0, 1'b1);
    end
    chk("simul_last", out_data, 32'h99);
    cycle(1'b0, '0, 1'b1);
    chk("simul_credit", 32'(credit_cnt), 32'd8);

    // Error flags: issue without credit, then that word overflows a stalled full FIFO
    for (int i = 0; i < DP; i++) cycle(1'b1, 32'h20 + 32'(i), 1'b0);
    repeat (PL) cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 32'hEE, 1'b0);
    chk("err_cred_set", 32'(err_cred), 32'd1);
    chk("err_cred_cnt0", 32'(credit_cnt), 32'd0);
    repeat (PL) cycle(1'b0, '0, 1'b0);
    chk("err_ovf_set", 32'(err_ovf), 32'd1);
    chk("err_ovf_head", out_data, 32'h20);
    repeat (3) cycle(1'b0, '0, 1'b1);

    // Asynchronous reset at occupancy 5
    chk("pre_rst_vld", 32'(out_vld), 32'd1);
    #2;
    a_rst_n = 1'b0;
    issue   = 1'b0;
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    #1;
    chk("arst_vld", 32'(out_vld), 32'd0);
    chk("arst_errs", 32'({err_ovf, err_cred}), 32'd0);
    model_reset();
    @(negedge clk);
    a_rst_n = 1'b1;
    @(negedge clk);
    chk("arst_credit", 32'(credit_cnt), 32'd8);
    check_all();

    // Randomized legal traffic
    for (int n = 0; n < 400; n++) begin
      cycle((mcred != 0) && ($urandom_range(0, 1) == 1), $urandom(), $urandom_range(0, 3) != 0);
    end
    repeat (PL + DP + 2) cycle(1'b0, '0, 1'b1);
    chk("rand_end_credit", 32'(credit_cnt), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
